mem_access: RTL and testbench

Memory-access stage of the MIPS pipeline, directly downstream of the EX stage. It consumes the EX `Result` (effective address or ALU value), the store operand `Rdata2` and the instruction word. It runs loads and stores against a variable-latency data-memory port and produces the write-back value and destination register for the register file. It stalls the upstream stages while a memory transaction is outstanding.

---
 rtl/mem_access_pkg.sv | 70 +++++++
 rtl/mem_access_if.sv | 23 ++
 rtl/mem_align.sv | 60 ++++++
 rtl/mem_access.sv | 176 +++++++++++++++++
 tb/tb_mem_access.sv | 317 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_pkg.sv
// Shared types and constants for the MIPS memory-access stage: opcode/funct codes,
// memory-op decode, FSM states and the write-back payload.
package mem_access_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned BE_W   = 4;

    localparam logic [5:0] OP_RFORM = 6'h00;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LB    = 6'h20;
    localparam logic [5:0] OP_LH    = 6'h21;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_LBU   = 6'h24;
    localparam logic [5:0] OP_LHU   = 6'h25;
    localparam logic [5:0] OP_SB    = 6'h28;
    localparam logic [5:0] OP_SH    = 6'h29;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] F_JR    = 6'h08;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;

    typedef enum logic [3:0] {
        MOP_NONE, MOP_LB, MOP_LH, MOP_LW, MOP_LBU, MOP_LHU, MOP_SB, MOP_SH, MOP_SW
    } mem_op_t;

    typedef enum logic {ST_IDLE, ST_ACCESS} state_t;

    typedef struct packed {
        logic              en;
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] data;
    } wb_t;

    function automatic mem_op_t decode_mem_op(input logic [5:0] opc);
        case (opc)
            OP_LB:   return MOP_LB;
            OP_LH:   return MOP_LH;
            OP_LW:   return MOP_LW;
            OP_LBU:  return MOP_LBU;
            OP_LHU:  return MOP_LHU;
            OP_SB:   return MOP_SB;
            OP_SH:   return MOP_SH;
            OP_SW:   return MOP_SW;
            default: return MOP_NONE;
        endcase
    endfunction

    function automatic logic is_load(input mem_op_t op);
        return op inside {MOP_LB, MOP_LH, MOP_LW, MOP_LBU, MOP_LHU};
    endfunction

    function automatic logic is_store(input mem_op_t op);
        return op inside {MOP_SB, MOP_SH, MOP_SW};
    endfunction

endpackage

// File: rtl/mem_access_if.sv
// Data-memory request/acknowledge port between the memory-access stage and data memory.
interface mem_access_if;
    import mem_access_pkg::*;

    logic              DmemReq;
    logic              DmemWe;
    logic [DATA_W-1:0] DmemAddr;
    logic [DATA_W-1:0] DmemWdata;
    logic [BE_W-1:0]   DmemBe;
    logic              DmemAck;
    logic [DATA_W-1:0] DmemRdata;

    modport master (
        output DmemReq, DmemWe, DmemAddr, DmemWdata, DmemBe,
        input  DmemAck, DmemRdata
    );

    modport slave (
        input  DmemReq, DmemWe, DmemAddr, DmemWdata, DmemBe,
        output DmemAck, DmemRdata
    );

endinterface

// File: rtl/mem_align.sv
// Combinational lane logic: store replicate/byte-enable/alignment check on the
// incoming op, and byte/half extract plus sign/zero extension on returned load data.
module mem_align
    import mem_access_pkg::*;
(
    input  mem_op_t           st_op,
    input  logic [1:0]        st_off,
    input  logic [DATA_W-1:0] st_data,
    output logic [DATA_W-1:0] st_wdata,
    output logic [BE_W-1:0]   st_be,
    output logic              misalign,
    input  mem_op_t           ld_op,
    input  logic [1:0]        ld_off,
    input  logic [DATA_W-1:0] ld_rdata,
    output logic [DATA_W-1:0] ld_value
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    assign ld_byte = ld_rdata[{ld_off, 3'b000} +: 8];
    assign ld_half = ld_rdata[{ld_off[1], 4'b0000} +: 16];

    // Store lanes and alignment for the op being accepted
    always_comb begin
        st_wdata = st_data;
        st_be    = '0;
        misalign = 1'b0;
        case (st_op)
            MOP_LB, MOP_LBU, MOP_SB: begin
                st_wdata = {4{st_data[7:0]}};
                st_be    = 4'b0001 << st_off;
            end
            MOP_LH, MOP_LHU, MOP_SH: begin
                st_wdata = {2{st_data[15:0]}};
                st_be    = 4'b0011 << st_off;
                misalign = st_off[0];
            end
            MOP_LW, MOP_SW: begin
                st_be    = 4'b1111;
                misalign = |st_off;
            end
            default: ;
        endcase
    end

    // Load extraction for the op waiting on the memory
    always_comb begin
        ld_value = '0;
        case (ld_op)
            MOP_LB:  ld_value = {{24{ld_byte[7]}}, ld_byte};
            MOP_LBU: ld_value = {24'd0, ld_byte};
            MOP_LH:  ld_value = {{16{ld_half[15]}}, ld_half};
            MOP_LHU: ld_value = {16'd0, ld_half};
            MOP_LW:  ld_value = ld_rdata;
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// MIPS memory-access stage: issues loads/stores on a variable-latency memory port,
// stalls upstream while a request is outstanding and produces register write-backs.
module mem_access
    import mem_access_pkg::*;
(
    input  logic              CLK,
    input  logic              RST,
    input  logic [DATA_W-1:0] Ins,
    input  logic [DATA_W-1:0] Result,
    input  logic [DATA_W-1:0] Rdata2,
    input  logic              InValid,
    output logic              Stall,
    mem_access_if.master      dmem,
    output logic              WbEn,
    output logic [REG_W-1:0]  WbReg,
    output logic [DATA_W-1:0] WbData,
    output logic              AddrErr
);

    state_t            state_q, state_d;
    logic              req_q, req_d, we_q, we_d, aerr_q, aerr_d;
    logic [DATA_W-1:0] addr_q, addr_d, wdata_q, wdata_d;
    logic [BE_W-1:0]   be_q, be_d;
    mem_op_t           ld_op_q, ld_op_d, in_op;
    logic [1:0]        ld_off_q, ld_off_d;
    logic [REG_W-1:0]  ld_rd_q, ld_rd_d, rd_dec;
    wb_t               wb_q, wb_d, pend_q, pend_d, ld_wb_c, new_wb_c;
    logic [5:0]        opcode, funct;
    logic              wr_result, accept, ack_done, misalign_c;
    logic [DATA_W-1:0] st_wdata_c, ld_value_c;
    logic [BE_W-1:0]   st_be_c;
    logic              unused_ins;

    assign opcode     = Ins[31:26];
    assign funct      = Ins[5:0];
    assign unused_ins = ^{Ins[25:21], Ins[10:6]};
    assign in_op      = decode_mem_op(opcode);
    assign Stall      = (state_q == ST_ACCESS) & ~dmem.DmemAck;
    assign accept     = InValid & ~Stall;
    assign ack_done   = (state_q == ST_ACCESS) & dmem.DmemAck;

    // Destination register and whether a non-memory op writes Result
    always_comb begin
        rd_dec    = '0;
        wr_result = 1'b0;
        case (opcode)
            OP_RFORM: begin
                rd_dec = Ins[15:11];
                case (funct)
                    F_MULT, F_MULTU, F_DIV, F_DIVU, F_MTHI, F_MTLO, F_JR: wr_result = 1'b0;
                    default: wr_result = 1'b1;
                endcase
            end
            OP_JAL: begin
                rd_dec    = 5'd31;
                wr_result = 1'b1;
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
                rd_dec    = Ins[20:16];
                wr_result = 1'b1;
            end
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: rd_dec = Ins[20:16];
            default: ;
        endcase
    end

    mem_align u_align (
        .st_op    (in_op),
        .st_off   (Result[1:0]),
        .st_data  (Rdata2),
        .st_wdata (st_wdata_c),
        .st_be    (st_be_c),
        .misalign (misalign_c),
        .ld_op    (ld_op_q),
        .ld_off   (ld_off_q),
        .ld_rdata (dmem.DmemRdata),
        .ld_value (ld_value_c)
    );

    assign ld_wb_c  = {ack_done & is_load(ld_op_q) & (ld_rd_q != '0), ld_rd_q, ld_value_c};
    assign new_wb_c = {accept & (in_op == MOP_NONE) & wr_result & (rd_dec != '0), rd_dec, Result};

    // Next state and registered outputs
    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        be_d     = be_q;
        ld_op_d  = ld_op_q;
        ld_off_d = ld_off_q;
        ld_rd_d  = ld_rd_q;
        aerr_d   = 1'b0;
        wb_d     = new_wb_c;
        pend_d   = '0;

        // One write-back port: a result that collides with an older one slips a cycle
        if (ld_wb_c.en) begin
            wb_d   = ld_wb_c;
            pend_d = new_wb_c;
        end else if (pend_q.en) begin
            wb_d   = pend_q;
            pend_d = new_wb_c;
        end

        case (state_q)
            ST_IDLE: ;
            ST_ACCESS: begin
                if (dmem.DmemAck) begin
                    state_d = ST_IDLE;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (accept && in_op != MOP_NONE) begin
            if (misalign_c) begin
                aerr_d = 1'b1;
            end else begin
                state_d  = ST_ACCESS;
                req_d    = 1'b1;
                we_d     = is_store(in_op);
                addr_d   = {Result[31:2], 2'b00};
                wdata_d  = st_wdata_c;
                be_d     = st_be_c;
                ld_op_d  = in_op;
                ld_off_d = Result[1:0];
                ld_rd_d  = rd_dec;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            be_q     <= '0;
            ld_op_q  <= MOP_NONE;
            ld_off_q <= '0;
            ld_rd_q  <= '0;
            wb_q     <= '0;
            pend_q   <= '0;
            aerr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            be_q     <= be_d;
            ld_op_q  <= ld_op_d;
            ld_off_q <= ld_off_d;
            ld_rd_q  <= ld_rd_d;
            wb_q     <= wb_d;
            pend_q   <= pend_d;
            aerr_q   <= aerr_d;
        end
    end

    assign dmem.DmemReq   = req_q;
    assign dmem.DmemWe    = we_q;
    assign dmem.DmemAddr  = addr_q;
    assign dmem.DmemWdata = wdata_q;
    assign dmem.DmemBe    = be_q;
    assign WbEn           = wb_q.en;
    assign WbReg          = wb_q.rd;
    assign WbData         = wb_q.data;
    assign AddrErr        = aerr_q;

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a queue-based reference model.
module tb_mem_access;

    logic        CLK = 1'b0;
    logic        RST;
    logic [31:0] Ins, Result, Rdata2;
    logic        InValid, Stall, WbEn, AddrErr;
    logic [4:0]  WbReg;
    logic [31:0] WbData;

    mem_access_if dmem();

    mem_access dut (
        .CLK(CLK), .RST(RST), .Ins(Ins), .Result(Result), .Rdata2(Rdata2),
        .InValid(InValid), .Stall(Stall), .dmem(dmem),
        .WbEn(WbEn), .WbReg(WbReg), .WbData(WbData), .AddrErr(AddrErr)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [31:0] rtype(input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, 5'd1, 5'd2, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] opc, input logic [4:0] rt);
        return {opc, 5'd1, rt, 16'h0};
    endfunction

    // ---------------- reference model ----------------
    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } wbe_t;

    wbe_t        wbq[$];
    wbe_t        ent;
    logic        m_busy = 1'b0;
    int          m_kind, m_off, kind, sz;
    logic [5:0]  m_opc;
    logic [4:0]  m_dst, dst;
    logic        wr, acc;
    logic        e_zero = 1'b1, e_wben = 1'b0, e_aerr = 1'b0, e_req = 1'b0, e_we = 1'b0;
    logic [4:0]  e_wbreg = '0;
    logic [31:0] e_wbdata = '0, e_addr = '0, e_wdata = '0;
    logic [3:0]  e_be = '0;

    // kind: 0 non-memory, 1 load, 2 store; wr set only for a real register write
    function automatic void classify(input logic [31:0] ins, output int k,
                                     output logic [4:0] d, output logic w, output int size);
        logic [5:0] opc, fn;
        opc = ins[31:26];
        fn  = ins[5:0];
        k = 0; d = 5'd0; w = 1'b0; size = 4;
        if (opc inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25}) begin
            k = 1; d = ins[20:16]; w = 1'b1;
        end else if (opc inside {6'h28, 6'h29, 6'h2B}) begin
            k = 2;
        end else if (opc == 6'h00) begin
            d = ins[15:11];
            w = !(fn inside {6'h18, 6'h19, 6'h1A, 6'h1B, 6'h11, 6'h13, 6'h08});
        end else if (opc == 6'h03) begin
            d = 5'd31; w = 1'b1;
        end else if (opc >= 6'h08 && opc <= 6'h0F) begin
            d = ins[20:16]; w = 1'b1;
        end
        if (d == 5'd0) w = 1'b0;
        if (opc inside {6'h20, 6'h24, 6'h28}) size = 1;
        else if (opc inside {6'h21, 6'h25, 6'h29}) size = 2;
    endfunction

    function automatic logic [31:0] load_value(input logic [5:0] opc, input int off, input logic [31:0] w);
        logic [31:0] s, v;
        s = w >> (8 * off);
        v = w;
        case (opc)
            6'h20: begin v = s & 32'hFF;   if (v >= 32'd128)   v = v - 32'd256;   end
            6'h24: v = s & 32'hFF;
            6'h21: begin v = s & 32'hFFFF; if (v >= 32'd32768) v = v - 32'd65536; end
            6'h25: v = s & 32'hFFFF;
            default: v = w;
        endcase
        return v;
    endfunction

    // Model: write-backs retire in order, one per cycle, as early as allowed
    always @(posedge CLK) begin
        if (RST) begin
            m_busy = 1'b0;
            wbq.delete();
            e_zero = 1'b1; e_wben = 1'b0; e_aerr = 1'b0; e_req = 1'b0;
        end else begin
            e_zero = 1'b0;
            e_aerr = 1'b0;
            acc = InValid & ~(m_busy & ~dmem.DmemAck);
            if (m_busy && dmem.DmemAck) begin
                m_busy = 1'b0;
                e_req  = 1'b0;
                if (m_kind == 1 && m_dst != 5'd0) begin
                    ent.rd = m_dst;
                    ent.data = load_value(m_opc, m_off, dmem.DmemRdata);
                    wbq.push_back(ent);
                end
            end
            if (acc) begin
                classify(Ins, kind, dst, wr, sz);
                if (kind == 0) begin
                    if (wr) begin
                        ent.rd = dst; ent.data = Result;
                        wbq.push_back(ent);
                    end
                end else if ((int'(Result[1:0]) % sz) != 0) begin
                    e_aerr = 1'b1;
                end else begin
                    m_busy = 1'b1; e_req = 1'b1; e_we = (kind == 2);
                    e_addr = Result & ~32'd3;
                    m_kind = kind; m_opc = Ins[31:26]; m_off = int'(Result[1:0]); m_dst = dst;
                    if (sz == 1) begin
                        e_be = 4'(1 << m_off); e_wdata = (Rdata2 & 32'hFF) * 32'h01010101;
                    end else if (sz == 2) begin
                        e_be = 4'(3 << m_off); e_wdata = (Rdata2 & 32'hFFFF) * 32'h00010001;
                    end else begin
                        e_be = 4'hF; e_wdata = Rdata2;
                    end
                end
            end
            if (wbq.size() > 0) begin
                ent = wbq.pop_front();
                e_wben = 1'b1; e_wbreg = ent.rd; e_wbdata = ent.data;
            end else begin
                e_wben = 1'b0;
            end
        end
    end

    // Compare process: DUT against model every cycle, away from the active edge
    always @(negedge CLK) begin
        if (e_zero) begin
            chk("rst_WbEn", 32'(WbEn), 32'd0);
            chk("rst_WbReg", 32'(WbReg), 32'd0);
            chk("rst_WbData", WbData, 32'd0);
            chk("rst_DmemReq", 32'(dmem.DmemReq), 32'd0);
            chk("rst_DmemWe", 32'(dmem.DmemWe), 32'd0);
            chk("rst_DmemAddr", dmem.DmemAddr, 32'd0);
            chk("rst_DmemWdata", dmem.DmemWdata, 32'd0);
            chk("rst_DmemBe", 32'(dmem.DmemBe), 32'd0);
            chk("rst_AddrErr", 32'(AddrErr), 32'd0);
            chk("rst_Stall", 32'(Stall), 32'd0);
        end else begin
            chk("Stall", 32'(Stall), 32'(m_busy & ~dmem.DmemAck));
            chk("WbEn", 32'(WbEn), 32'(e_wben));
            if (e_wben) begin
                chk("WbReg", 32'(WbReg), 32'(e_wbreg));
                chk("WbData", WbData, e_wbdata);
            end
            chk("AddrErr", 32'(AddrErr), 32'(e_aerr));
            chk("DmemReq", 32'(dmem.DmemReq), 32'(e_req));
            if (e_req) begin
                chk("DmemAddr", dmem.DmemAddr, e_addr);
                chk("DmemWe", 32'(dmem.DmemWe), 32'(e_we));
                if (e_we) begin
                    chk("DmemBe", 32'(dmem.DmemBe), 32'(e_be));
                    chk("DmemWdata", dmem.DmemWdata, e_wdata);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [5:0] opcs [22] = '{6'h00, 6'h00, 6'h00, 6'h03, 6'h08, 6'h09, 6'h0A, 6'h0B,
                             6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h02, 6'h04, 6'h20, 6'h21,
                             6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B};
    logic [5:0] fns [16]  = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h2A, 6'h10, 6'h12,
                             6'h09, 6'h18, 6'h19, 6'h1A, 6'h1B, 6'h08, 6'h11, 6'h13};

    task automatic load_case(input string nm, input logic [5:0] opc, input logic [31:0] exp);
        int n_stall;
        Ins = itype(opc, 5'd3); Result = 32'h101; InValid = 1'b1;
        step();
        InValid = 1'b0;
        chk({nm, "_addr"}, dmem.DmemAddr, 32'h100);
        chk({nm, "_req"}, 32'(dmem.DmemReq), 32'd1);
        n_stall = 0;
        repeat (2) begin
            #1;
            if (Stall) n_stall++;
            step();
        end
        dmem.DmemAck = 1'b1; dmem.DmemRdata = 32'h11228033;
        #1;
        if (Stall) n_stall++;
        step();
        dmem.DmemAck = 1'b0;
        chk({nm, "_stall_cycles"}, 32'(n_stall), 32'd2);
        chk({nm, "_WbEn"}, 32'(WbEn), 32'd1);
        chk({nm, "_WbReg"}, 32'(WbReg), 32'd3);
        chk({nm, "_WbData"}, WbData, exp);
    endtask

    initial begin
        RST = 1'b1; InValid = 1'b0; Ins = '0; Result = '0; Rdata2 = '0;
        dmem.DmemAck = 1'b0; dmem.DmemRdata = '0;
        repeat (2) step();
        chk("reset_WbEn", 32'(WbEn), 32'd0);
        chk("reset_DmemReq", 32'(dmem.DmemReq), 32'd0);
        RST = 1'b0;

        // ADDU rd=5
        Ins = rtype(5'd5, 6'h21); Result = 32'h1234; InValid = 1'b1;
        step();
        InValid = 1'b0;
        chk("addu_Stall", 32'(Stall), 32'd0);
        chk("addu_WbEn", 32'(WbEn), 32'd1);
        chk("addu_WbReg", 32'(WbReg), 32'd5);
        chk("addu_WbData", WbData, 32'h1234);
        step();

        load_case("lb", 6'h20, 32'hFFFFFF80);
        load_case("lbu", 6'h24, 32'h00000080);

        // SH to 0x202
        Ins = itype(6'h29, 5'd4); Result = 32'h202; Rdata2 = 32'hABCD1234; InValid = 1'b1;
        step();
        InValid = 1'b0;
        chk("sh_We", 32'(dmem.DmemWe), 32'd1);
        chk("sh_Be", 32'(dmem.DmemBe), 32'hC);
        chk("sh_Wdata", dmem.DmemWdata, 32'h12341234);
        dmem.DmemAck = 1'b1;
        step();
        dmem.DmemAck = 1'b0;
        chk("sh_WbEn", 32'(WbEn), 32'd0);

        // Misaligned LW, then ADDU the next cycle
        Ins = itype(6'h23, 5'd6); Result = 32'h103; InValid = 1'b1;
        step();
        Ins = rtype(5'd7, 6'h21); Result = 32'h55;
        chk("lwmis_AddrErr", 32'(AddrErr), 32'd1);
        chk("lwmis_Req", 32'(dmem.DmemReq), 32'd0);
        chk("lwmis_WbEn", 32'(WbEn), 32'd0);
        step();
        InValid = 1'b0;
        chk("after_mis_WbReg", 32'(WbReg), 32'd7);
        chk("after_mis_AddrErr", 32'(AddrErr), 32'd0);

        // LW acked in first request cycle, ADD right behind it
        Ins = itype(6'h23, 5'd9); Result = 32'h300; InValid = 1'b1;
        step();
        dmem.DmemAck = 1'b1; dmem.DmemRdata = 32'hCAFEF00D;
        Ins = rtype(5'd10, 6'h20); Result = 32'h77;
        step();
        InValid = 1'b0; dmem.DmemAck = 1'b0;
        chk("b2b_lw_WbReg", 32'(WbReg), 32'd9);
        chk("b2b_lw_WbData", WbData, 32'hCAFEF00D);
        step();
        chk("b2b_add_WbEn", 32'(WbEn), 32'd1);
        chk("b2b_add_WbData", WbData, 32'h77);
        step();

        // Reset while waiting for ack, then a late ack
        Ins = itype(6'h23, 5'd11); Result = 32'h400; InValid = 1'b1;
        step();
        InValid = 1'b0;
        step();
        RST = 1'b1;
        step();
        RST = 1'b0;
        chk("rstacc_Req", 32'(dmem.DmemReq), 32'd0);
        dmem.DmemAck = 1'b1; dmem.DmemRdata = 32'h12345678;
        step();
        dmem.DmemAck = 1'b0;
        chk("late_ack_WbEn", 32'(WbEn), 32'd0);
        chk("late_ack_Req", 32'(dmem.DmemReq), 32'd0);

        // Randomized traffic; upstream holds its inputs while a request is outstanding
        for (int c = 0; c < 4000; c++) begin
            if (!m_busy) begin
                Ins = $urandom();
                Ins[31:26] = opcs[$urandom_range(0, 21)];
                if (Ins[31:26] == 6'h00) Ins[5:0] = fns[$urandom_range(0, 15)];
                if ($urandom_range(0, 7) == 0) begin
                    Ins[20:16] = 5'd0;
                    Ins[15:11] = 5'd0;
                end
                Result = $urandom();
                if ($urandom_range(0, 1) == 1) Result[1:0] = 2'b00;
                Rdata2 = $urandom();
                InValid = ($urandom_range(0, 3) != 0);
            end
            dmem.DmemAck   = ($urandom_range(0, 99) < 35);
            dmem.DmemRdata = $urandom();
            RST = ($urandom_range(0, 199) == 0);
            step();
        end
        RST = 1'b0; InValid = 1'b0; dmem.DmemAck = 1'b0;
        repeat (3) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
